dfr_mem_arbiter: RTL and testbench
==================================

Name: dfr_mem_arbiter

Overview:
Round-robin arbiter sharing one single-port, 1-cycle-latency BRAM among NUM_REQ requesters. Port 0 is host register access, port 1 is reservoir history write, port 2 is matrix-multiply weight/output access. Supports locked bursts, so a requester can hold the memory for consecutive beats. Host access is masked while the DFR core is busy.

Parameters:
ADDR_WIDTH, 32, memory word address width
DATA_WIDTH, 32, memory data width
NUM_REQ, 3, number of requesters (>=2); index 0 = host

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
host_block  in  1  masks req[0] while high (driven by core busy)
req  in  NUM_REQ  per-requester access request
lock  in  NUM_REQ  hold grant after current beat while asserted
we  in  NUM_REQ  1=write, 0=read, per requester
addr  in  NUM_REQ*ADDR_WIDTH  flat; slice i = requester i
wdata  in  NUM_REQ*DATA_WIDTH  flat; slice i = requester i
gnt  out  NUM_REQ  one-hot grant; beat accepted when req[i]&gnt[i]
rvalid  out  NUM_REQ  read data valid for requester i
rdata  out  DATA_WIDTH  broadcast read data, qualified by rvalid
mem_en  out  1  BRAM enable
mem_we  out  1  BRAM write enable
mem_addr  out  ADDR_WIDTH  BRAM address
mem_wdata  out  DATA_WIDTH  BRAM write data
mem_rdata  in  DATA_WIDTH  BRAM read data, valid 1 cycle after mem_en&~mem_we

Behaviour:
- Reset: state IDLE, rr_ptr=0, owner=0, gnt=0, rvalid=0, mem_en=0, mem_we=0. mem_addr and mem_wdata are driven from the zero-selected mux but are don't-care while mem_en=0.
- eff_req = req & ~{host_block at bit 0}.
- gnt is combinational, at most one bit set, and zero when eff_req=0.
- mem_en = |gnt. mem_we, mem_addr and mem_wdata are muxed combinationally from the granted slice.
- Zero-cycle grant: a beat issues in the same cycle req is seen.
- States: IDLE and LOCKED.
- IDLE arbitration: grant the first eff_req bit at or after rr_ptr, scanning upward with wrap from NUM_REQ-1 to 0.
- IDLE on grant to i: rr_ptr <= (i+1) mod NUM_REQ. If lock[i], owner <= i and go to LOCKED.
- LOCKED: gnt = eff_req[owner] ? onehot(owner) : 0. Other requests are ignored.
- LOCKED exit: go to IDLE when lock[owner]=0 on a granted beat (that beat is the last), or when eff_req[owner]=0 (release without a beat).
- Simultaneous exit and new requests: no same-cycle handover. Others are arbitrated from the next cycle.
- host_block rising while host holds the lock: eff_req[0] drops, so the lock releases the following cycle. An in-flight read still returns.
- Read return: rd_pend <= gnt & ~{NUM_REQ{mem_we}} on each cycle. rvalid = rd_pend, registered and aligned with mem_rdata. rdata = mem_rdata passed through.
- Reads are fully pipelined: back-to-back reads give back-to-back rvalid.
- Writes produce no rvalid.
- Reset mid-operation: rd_pend is cleared, no rvalid is produced for outstanding reads, and the lock is dropped.
- Fairness: without lock, any continuously requesting port is granted within NUM_REQ cycles.

Decomposition:
- Shared package dfr_pkg holds the requester index constants (REQ_HOST=0, REQ_HIST=1, REQ_MMULT=2) and the arb state enum {ARB_IDLE, ARB_LOCKED}.
- One natural sub-module: rr_priority_select. It is combinational: eff_req plus rr_ptr produce a one-hot grant and a binary index.

Test Plan:
- Reset mid-read: reset asserted the cycle after a read grant -> rvalid stays 0, gnt=0, rr_ptr=0 after release.
- Round-robin fairness: req=3'b111 held for 6 cycles, no lock -> gnt sequence 001,010,100,001,010,100.
- Read latency: req[2] reads addr 0x10, BRAM preloaded 0xDEADBEEF -> mem_en=1,mem_we=0,mem_addr=0x10 in cycle N; rvalid=3'b100, rdata=0xDEADBEEF in cycle N+1.
- Locked burst: req[1] with lock high for 4 writes to addr 0..3 while req[0],req[2] held -> gnt=010 for 4 cycles. lock drops on beat 4, then next grant is 100 (rr_ptr=2).
- Host masking: host_block=1 with req=3'b001 -> gnt=0, mem_en=0. host_block=0 -> gnt=001 the same cycle.
- Host lock preempted by block: host locked, host_block rises -> gnt[0]=0 that cycle, state IDLE next cycle, req[2] granted.

Source files
------------

// File: rtl/dfr_pkg.sv
// Shared definitions for the DFR memory arbiter.
//   REQ_*       : requester index assignments on the shared BRAM
//   arb_state_e : arbiter state (free arbitration vs. locked burst)
package dfr_pkg;

  localparam int unsigned REQ_HOST  = 0;
  localparam int unsigned REQ_HIST  = 1;
  localparam int unsigned REQ_MMULT = 2;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin priority select.
//   req   : request vector to arbitrate
//   ptr   : highest-priority index; scan goes upward and wraps to 0
//   gnt   : one-hot grant, zero when req is zero
//   idx   : binary index of the granted bit (0 when nothing granted)
//   valid : a grant was found
module rr_priority_select #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          valid
);

  // First set bit at or after ptr, modulo N.
  always_comb begin
    int unsigned j;
    logic [PW-1:0] j_idx;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    j_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end
      j_idx = PW'(j);
      if (!valid && req[j_idx]) begin
        valid      = 1'b1;
        gnt[j_idx] = 1'b1;
        idx        = j_idx;
      end
    end
  end

endmodule

// File: rtl/dfr_mem_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency BRAM among
// NUM_REQ requesters, with locked bursts and host masking.
//   clk, rst     : clock, asynchronous active-high reset
//   host_block   : masks req[0] while high
//   req/lock/we  : per-requester request, burst lock, write enable
//   addr/wdata   : flat per-requester buses, slice i = requester i
//   gnt          : one-hot zero-cycle grant (combinational)
//   rvalid/rdata : read return, one cycle after a granted read
//   mem_*        : BRAM port
module dfr_mem_arbiter
  import dfr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            host_block,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              lock,
  input  logic [NUM_REQ-1:0]              we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rvalid,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] HOST_MASK = NUM_REQ'(1) << REQ_HOST;
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0] rd_pend_q, rd_pend_d;

  logic [NUM_REQ-1:0] eff_req;
  logic [NUM_REQ-1:0] sel_gnt;
  logic [PW-1:0]      sel_idx;
  logic               sel_valid;
  logic [PW-1:0]      gidx;

  logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];

  // Host request is hidden while the core is busy.
  assign eff_req = req & ~({NUM_REQ{host_block}} & HOST_MASK);

  // Unpack the flat per-requester buses.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_a[i]  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_a[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  rr_priority_select #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_sel (
    .req   (eff_req),
    .ptr   (rr_ptr_q),
    .gnt   (sel_gnt),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  // Next-state and grant logic.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    gnt      = '0;
    gidx     = '0;
    case (state_q)
      ARB_IDLE: begin
        if (sel_valid) begin
          gnt      = sel_gnt;
          gidx     = sel_idx;
          rr_ptr_d = (sel_idx == LAST_IDX) ? '0 : sel_idx + PW'(1);
          if (lock[sel_idx]) begin
            owner_d = sel_idx;
            state_d = ARB_LOCKED;
          end
        end
      end
      ARB_LOCKED: begin
        // Owner keeps the memory; others wait. Release on the last beat
        // or as soon as the owner stops (or is masked from) requesting.
        if (eff_req[owner_q]) begin
          gnt[owner_q] = 1'b1;
          gidx         = owner_q;
          if (!lock[owner_q]) begin
            state_d = ARB_IDLE;
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // No beat may issue while reset is held.
    if (rst) begin
      gnt  = '0;
      gidx = '0;
    end
  end

  // BRAM port mux; index 0 is selected when idle.
  assign mem_en    = |gnt;
  assign mem_we    = mem_en & we[gidx];
  assign mem_addr  = addr_a[gidx];
  assign mem_wdata = wdata_a[gidx];

  // Reads return one cycle later, aligned with mem_rdata.
  assign rd_pend_d = gnt & ~{NUM_REQ{mem_we}};
  assign rvalid    = rd_pend_q;
  assign rdata     = mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      rd_pend_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      rd_pend_q <= rd_pend_d;
    end
  end

endmodule

// File: tb/tb_dfr_mem_arbiter.sv
// Self-checking bench for dfr_mem_arbiter: behavioural model plus directed
// scenarios with literal expectations, then randomized traffic.
module tb_dfr_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic host_block = 1'b0;
  logic [N-1:0] req = '0, lock = '0, we = '0;
  logic [AW-1:0] addr_a  [N];
  logic [DW-1:0] wdata_a [N];
  logic [N*AW-1:0] addr_f;
  logic [N*DW-1:0] wdata_f;
  logic [N-1:0]  gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  // Next-cycle stimulus, applied by step()
  logic nx_rst, nx_hb;
  logic [N-1:0] nx_req, nx_lock, nx_we;
  logic [AW-1:0] nx_addr [N];
  logic [DW-1:0] nx_wdata [N];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit      m_locked = 0;
  int      m_owner  = 0;
  int      m_ptr    = 0;
  logic [N-1:0]  m_rv    = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] bram    [logic [AW-1:0]];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      addr_f[i*AW +: AW]  = addr_a[i];
      wdata_f[i*DW +: DW] = wdata_a[i];
    end
  end

  dfr_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .host_block(host_block),
    .req(req), .lock(lock), .we(we), .addr(addr_f), .wdata(wdata_f),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Bench-side BRAM, 1-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] = mem_wdata;
      else mem_rdata <= bram.exists(mem_addr) ? bram[mem_addr] : '0;
    end
  end

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic set_in(input logic r, input logic hb, input logic [N-1:0] rq,
                        input logic [N-1:0] lk, input logic [N-1:0] w);
    nx_rst = r; nx_hb = hb; nx_req = rq; nx_lock = lk; nx_we = w;
  endtask

  // One cycle: apply stimulus, compare DUT against model, advance model.
  task automatic step();
    logic [N-1:0] eff, g_exp;
    int gi;
    @(posedge clk);
    #1;
    rst = nx_rst; host_block = nx_hb; req = nx_req; lock = nx_lock; we = nx_we;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = nx_addr[i];
      wdata_a[i] = nx_wdata[i];
    end
    #1;
    eff = req;
    if (host_block) eff[0] = 1'b0;
    gi = -1;
    if (!rst) begin
      if (!m_locked) begin
        for (int k = 0; k < N; k++) begin
          if (gi < 0 && eff[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
        end
      end else if (eff[m_owner]) begin
        gi = m_owner;
      end
    end
    g_exp = (gi >= 0) ? N'(1 << gi) : '0;
    chk("gnt", 64'(gnt), 64'(g_exp));
    chk("mem_en", 64'(mem_en), 64'(gi >= 0));
    if (gi >= 0) begin
      chk("mem_we", 64'(mem_we), 64'(we[gi]));
      chk("mem_addr", 64'(mem_addr), 64'(addr_a[gi]));
      if (we[gi]) chk("mem_wdata", 64'(mem_wdata), 64'(wdata_a[gi]));
    end else begin
      chk("mem_we_idle", 64'(mem_we), 64'(0));
    end
    chk("rvalid", 64'(rvalid), rst ? 64'(0) : 64'(m_rv));
    if (!rst && m_rv != '0) chk("rdata", 64'(rdata), 64'(m_rdata));
    if (rst) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_rv = '0;
    end else begin
      m_rv = '0;
      if (gi >= 0) begin
        if (we[gi]) ref_mem[addr_a[gi]] = wdata_a[gi];
        else begin
          m_rv = N'(1 << gi);
          m_rdata = ref_rd(addr_a[gi]);
        end
      end
      if (!m_locked) begin
        if (gi >= 0) begin
          m_ptr = (gi + 1) % N;
          if (lock[gi]) begin
            m_locked = 1;
            m_owner = gi;
          end
        end
      end else if (gi < 0 || !lock[m_owner]) begin
        m_locked = 0;
      end
    end
  endtask

  initial begin
    logic [N-1:0] fair_seq [6];
    fair_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < N; i++) begin
      addr_a[i] = '0; wdata_a[i] = '0; nx_addr[i] = '0; nx_wdata[i] = '0;
    end
    bram[32'h10] = 32'hDEAD_BEEF;
    ref_mem[32'h10] = 32'hDEAD_BEEF;

    // Reset state
    set_in(1, 0, 3'b000, 3'b000, 3'b000); step();
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_mem_en", 64'(mem_en), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));

    // Round-robin fairness
    set_in(0, 0, 3'b111, 3'b000, 3'b000);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("fair_gnt", 64'(gnt), 64'(fair_seq[k]));
    end

    // Read latency
    nx_addr[2] = 32'h10;
    set_in(0, 0, 3'b100, 3'b000, 3'b000); step();
    chk("rd_gnt", 64'(gnt), 64'(3'b100));
    chk("rd_mem_en", 64'(mem_en), 64'(1));
    chk("rd_mem_we", 64'(mem_we), 64'(0));
    chk("rd_mem_addr", 64'(mem_addr), 64'(32'h10));
    set_in(0, 0, 3'b000, 3'b000, 3'b000); step();
    chk("rd_rvalid", 64'(rvalid), 64'(3'b100));
    chk("rd_rdata", 64'(rdata), 64'(32'hDEAD_BEEF));

    // Locked burst from requester 1 (pointer moved to 1 first)
    set_in(0, 0, 3'b001, 3'b000, 3'b000); step();
    for (int b = 0; b < 4; b++) begin
      nx_addr[1] = AW'(b);
      nx_wdata[1] = 32'hA000 + DW'(b);
      set_in(0, 0, 3'b111, (b < 3) ? 3'b010 : 3'b000, 3'b111); step();
      chk("burst_gnt", 64'(gnt), 64'(3'b010));
    end
    set_in(0, 0, 3'b111, 3'b000, 3'b000); step();
    chk("post_burst_gnt", 64'(gnt), 64'(3'b100));
    nx_addr[1] = 32'h2;
    set_in(0, 0, 3'b010, 3'b000, 3'b000); step();
    set_in(0, 0, 3'b000, 3'b000, 3'b000); step();
    chk("burst_rb_rvalid", 64'(rvalid), 64'(3'b010));
    chk("burst_rb_rdata", 64'(rdata), 64'(32'hA002));

    // Host masking
    set_in(0, 1, 3'b001, 3'b000, 3'b000); step();
    chk("mask_gnt", 64'(gnt), 64'(0));
    chk("mask_mem_en", 64'(mem_en), 64'(0));
    set_in(0, 0, 3'b001, 3'b000, 3'b000); step();
    chk("unmask_gnt", 64'(gnt), 64'(3'b001));

    // Host lock preempted by host_block
    set_in(0, 0, 3'b100, 3'b000, 3'b000); step();
    set_in(0, 0, 3'b101, 3'b001, 3'b000); step();
    chk("hlock_gnt", 64'(gnt), 64'(3'b001));
    set_in(0, 1, 3'b101, 3'b001, 3'b000); step();
    chk("hblock_gnt", 64'(gnt), 64'(0));
    step();
    chk("hblock_next_gnt", 64'(gnt), 64'(3'b100));

    // Reset mid-read
    set_in(0, 0, 3'b010, 3'b000, 3'b000); step();
    chk("mr_gnt", 64'(gnt), 64'(3'b010));
    set_in(1, 0, 3'b010, 3'b000, 3'b000); step();
    chk("mr_rvalid", 64'(rvalid), 64'(0));
    chk("mr_gnt_rst", 64'(gnt), 64'(0));
    set_in(0, 0, 3'b111, 3'b000, 3'b000); step();
    chk("mr_after_gnt", 64'(gnt), 64'(3'b001));
    chk("mr_after_rvalid", 64'(rvalid), 64'(0));

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        nx_addr[i] = AW'($urandom_range(0, 15));
        nx_wdata[i] = $urandom;
      end
      set_in($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
             N'($urandom), N'($urandom) & N'($urandom), N'($urandom));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
